// File: rtl/ss_mac_seq_if.sv
// Handshake/data bundle for ss_mac_seq.
// master: the job issuer / result consumer side. slave: the MAC itself.
interface ss_mac_seq_if #(
  parameter int NCH   = 8,
  parameter int IW    = 11,
  parameter int RW    = 8,
  parameter int ACC_W = 10,
  parameter int LW    = 8
) ();
  logic [NCH*IW-1:0] x_input;
  logic [NCH*RW-1:0] x_randnum;
  logic              start;
  logic [LW-1:0]     len;
  logic              busy;
  logic [ACC_W-1:0]  z_output;
  logic              z_valid;
  logic              z_ready;
  logic              ovf;

  modport master (
    output x_input, x_randnum, start, len, z_ready,
    input  busy, z_output, z_valid, ovf
  );

  modport slave (
    input  x_input, x_randnum, start, len, z_ready,
    output busy, z_output, z_valid, ovf
  );
endinterface

// File: rtl/ss_mac_seq.sv
// Self-sequencing stochastic-symbol MAC.
// Each cycle in RUN one channel (round-robin from 0) converts its live operand
// and random number into a symbol that is added into the accumulator; after
// len symbols the result is offered on a valid/ready handshake with a sticky
// overflow flag.
// Build option: define SS_MAC_SAT_EN to clamp the accumulator at 2^ACC_W-1 on
// overflow; left undefined, the accumulator wraps modulo 2^ACC_W.
module ss_mac_seq #(
  parameter int NCH   = 8,
  parameter int IW    = 11,
  parameter int RW    = 8,
  parameter int SW    = IW - RW + 1,
  parameter int ACC_W = 10,
  parameter int LW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  ss_mac_seq_if.slave    bus
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CH_W-1:0]  ch;
  logic [LW-1:0]    cnt;
  logic             z_valid;
  logic             busy;
  logic             ovf;

  logic [IW-1:0]    x_sel;
  logic [RW-1:0]    r_sel;
  logic [SW-1:0]    sym;
  logic [SUM_W-1:0] sum;

  // Carry bit of the widened sum marks an overflowing add; the result either
  // clamps to full scale or keeps the low ACC_W bits (wrap).
  function automatic logic [ACC_W-1:0] acc_limit(input logic [SUM_W-1:0] s);
`ifdef SS_MAC_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  // Symbol of the currently selected channel: integer part of the operand
  // plus one when its fraction strictly beats the random number.
  always_comb begin
    x_sel = bus.x_input[ch*IW +: IW];
    r_sel = bus.x_randnum[ch*RW +: RW];
    sym   = SW'(x_sel[IW-1:RW]) + ((x_sel[RW-1:0] > r_sel) ? SW'(1) : SW'(0));
    sum   = {1'b0, acc} + SUM_W'(sym);
  end

  // Job sequencer: IDLE -> RUN (len adds) -> DONE (hold until accepted).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      ch      <= '0;
      cnt     <= '0;
      z_valid <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            ch   <= '0;
            busy <= 1'b1;
            if (bus.len != '0) begin
              cnt   <= bus.len;
              state <= RUN;
            end else begin
              cnt     <= '0;
              z_valid <= 1'b1;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          acc <= acc_limit(sum);
          if (sum[ACC_W]) ovf <= 1'b1;
          ch  <= (ch == CH_W'(NCH - 1)) ? '0 : ch + 1'b1;
          cnt <= cnt - LW'(1);
          if (cnt == LW'(1)) begin
            z_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.z_ready) begin
            z_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.z_output = acc;
  assign bus.z_valid  = z_valid;
  assign bus.busy     = busy;
  assign bus.ovf      = ovf;

endmodule

// File: tb/tb_ss_mac_seq.sv
// Directed bench for ss_mac_seq at default parameters.
module tb_ss_mac_seq;

  localparam int NCH   = 8;
  localparam int IW    = 11;
  localparam int RW    = 8;
  localparam int ACC_W = 10;
  localparam int LW    = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  ss_mac_seq_if #(.NCH(NCH), .IW(IW), .RW(RW), .ACC_W(ACC_W), .LW(LW)) bus ();

  ss_mac_seq #(.NCH(NCH), .IW(IW), .RW(RW), .ACC_W(ACC_W), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x_all(input logic [IW-1:0] v);
    for (int i = 0; i < NCH; i++) bus.x_input[i*IW +: IW] = v;
  endtask

  task automatic set_r_all(input logic [RW-1:0] v);
    for (int i = 0; i < NCH; i++) bus.x_randnum[i*RW +: RW] = v;
  endtask

  task automatic go(input logic [LW-1:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic accept();
    bus.z_ready = 1'b1;
    tick();
    bus.z_ready = 1'b0;
  endtask

  int n;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.len = '0;
    bus.z_ready = 1'b0;
    set_x_all('0);
    set_r_all('0);
    tick();
    tick();
    chk("rst_valid", 32'(bus.z_valid), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_z",     32'(bus.z_output), 0);
    chk("rst_ovf",   32'(bus.ovf), 0);
    rst = 1'b1;
    tick();

    // 1: every symbol = 1, eight of them
    set_x_all(11'h100);
    set_r_all(8'd0);
    go(8'd8);
    chk("t1_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 7; i++) tick();
    chk("t1_early", 32'(bus.z_valid), 0);
    tick();
    chk("t1_valid", 32'(bus.z_valid), 1);
    chk("t1_z", 32'(bus.z_output), 8);
    chk("t1_ovf", 32'(bus.ovf), 0);
    accept();
    chk("t1_drop", 32'(bus.z_valid), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // 2: channel i yields symbol i; order 0..7,0,1
    for (int i = 0; i < NCH; i++) bus.x_input[i*IW +: IW] = IW'(i << 8);
    set_r_all(8'hFF);
    go(8'd10);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_valid", 32'(bus.z_valid), 1);
    chk("t2_z", 32'(bus.z_output), 29);
    accept();

    // 3: strict comparison at the rounding boundary
    set_x_all(11'h080);
    go(8'd4);
    set_r_all(8'd127);
    tick();
    tick();
    tick();
    set_r_all(8'd128);
    tick();
    chk("t3_valid", 32'(bus.z_valid), 1);
    chk("t3_z", 32'(bus.z_output), 3);
    accept();

    // 4: overflow, 200 symbols of 8
    set_x_all(11'h7FF);
    set_r_all(8'd0);
    go(8'd200);
    n = 0;
    while (!bus.z_valid && n < 250) begin
      tick();
      n++;
    end
    chk("t4_latency", 32'(n), 200);
    chk("t4_ovf", 32'(bus.ovf), 1);
`ifdef SS_MAC_SAT_EN
    chk("t4_z", 32'(bus.z_output), 1023);
`else
    chk("t4_z", 32'(bus.z_output), 576);
`endif
    accept();
    chk("t4_ovf_held", 32'(bus.ovf), 1);

    // 5: zero-length job, held result, start ignored in DONE
    go(8'd0);
    chk("t5_valid", 32'(bus.z_valid), 1);
    chk("t5_z", 32'(bus.z_output), 0);
    chk("t5_ovf_clr", 32'(bus.ovf), 0);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      bus.len   = 8'd5;
      tick();
      chk("t5_hold_valid", 32'(bus.z_valid), 1);
      chk("t5_hold_z", 32'(bus.z_output), 0);
    end
    bus.start = 1'b0;
    accept();
    chk("t5_drop", 32'(bus.z_valid), 0);
    chk("t5_busy", 32'(bus.busy), 0);

    // 6: reset mid-job, then a clean len=2 job
    set_x_all(11'h100);
    set_r_all(8'd0);
    go(8'd8);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_valid", 32'(bus.z_valid), 0);
    chk("t6_z", 32'(bus.z_output), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    go(8'd2);
    tick();
    chk("t6_early", 32'(bus.z_valid), 0);
    tick();
    chk("t6_valid2", 32'(bus.z_valid), 1);
    chk("t6_z2", 32'(bus.z_output), 2);
    accept();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
